// File: rtl/frequency_divider.sv
//------------------------------------------------------------------------------
// frequency_divider
//
// Synchronous integer clock divider. A free-running counter wraps every DIV
// input cycles. A toggle register flips twice per wrap, so the output has a
// period of exactly DIV input cycles. The output comes straight from a flop,
// which keeps it glitch-free.
//
// Parameters:
//   DIV     integer divide ratio (>= 2). Elaboration stops if DIV < 2.
//
// Ports:
//   clk_in  input   reference clock; state updates on its rising edge
//   rst_n   input   synchronous active-low reset, sampled at posedge clk_in
//   clk_out output  divided clock, f_in / DIV
//
// Optional feature (macro FREQ_DIV_ODD_DUTY50_EN):
//   For odd DIV, a falling-edge copy of the toggle register is ANDed with it.
//   This trims the high phase by half an input cycle and gives exactly 50%
//   duty. Even DIV builds are unaffected. With the macro undefined there is no
//   negedge logic, and odd DIV is high for DIV-DIV/2 cycles and low for DIV/2.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module frequency_divider #(
    parameter int DIV = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic clk_out
);

    // The guard keeps the width legal long enough for the DIV check below to
    // produce a readable error instead of a width error.
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int H     = DIV / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("frequency_divider: DIV must be >= 2 (got %0d)", DIV);
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_q;
    logic             out_d;

    // The output toggles at the end of the first half (cnt == H-1) and again
    // at the wrap (cnt == DIV-1). For DIV=2 these are consecutive counts, so
    // the output flips on every edge.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        out_d = out_q;
        if ((cnt_q == CNT_HALF) || (cnt_q == CNT_LAST)) begin
            out_d = ~out_q;
        end
    end

    // A reset edge abandons the current period at once. The first high phase
    // after release starts H edges later.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

`ifdef FREQ_DIV_ODD_DUTY50_EN
    generate
        if ((DIV % 2) == 1) begin : g_odd_duty50
            // neg_q follows out_q half a cycle late. ANDing the two delays the
            // rising edge by half a cycle and leaves the falling edge
            // untouched. neg_q is 0 whenever out_q rises, so the AND cannot
            // glitch.
            logic neg_q;

            always_ff @(negedge clk_in) begin
                neg_q <= rst_n ? out_q : 1'b0;
            end

            assign clk_out = out_q & neg_q;
        end else begin : g_even_base
            assign clk_out = out_q;
        end
    endgenerate
`else
    assign clk_out = out_q;
`endif

endmodule

// File: tb/tb_frequency_divider.sv
//------------------------------------------------------------------------------
// tb_frequency_divider
//
// Drives three dividers (DIV=12, 2, 5) from one 20 ns clock.
//
// Each cycle the bench drives reset, advances its own phase model and pushes
// the expected outputs to a scoreboard. It then pops that entry and compares
// it with the DUT just after the rising edge. The DIV=5 entry is compared a
// second time after the falling edge.
//
// Pulse widths are measured from output edge times. The DIV=12 divider also
// gets a one-cycle reset in the middle of a high phase, and the first rise
// after each release is timed.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_frequency_divider;

`ifdef FREQ_DIV_ODD_DUTY50_EN
    localparam bit DUTY50 = 1'b1;
`else
    localparam bit DUTY50 = 1'b0;
`endif

    localparam int HI5_NS = DUTY50 ? 50 : 60;
    localparam int LO5_NS = DUTY50 ? 50 : 40;
    localparam int N_CYC  = 200;

    typedef struct {
        int   cyc;
        logic d12;
        logic d2;
        logic d5_hi;   // DIV=5 output in the high half of clk_in
        logic d5_lo;   // DIV=5 output in the low half of clk_in
    } exp_t;

    logic clk;
    logic rst12, rst2, rst5;
    logic clk_out12, clk_out2, clk_out5;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    // Phase model: k = rising edges since the last reset edge.
    // The output is high when (k mod DIV) >= DIV/2.
    int k12, k2, k5, k5_prev;

    real t_rel12;
    bit  rise_pending;
    bit  mid_done;

    real t_rise[3];
    real t_fall[3];
    bit  seen_rise[3];
    bit  seen_fall[3];
    bit  w_en[3];

    frequency_divider #(12) u_div12 (.clk_in(clk), .rst_n(rst12), .clk_out(clk_out12));
    frequency_divider #(2)  u_div2  (.clk_in(clk), .rst_n(rst2),  .clk_out(clk_out2));
    frequency_divider #(5)  u_div5  (.clk_in(clk), .rst_n(rst5),  .clk_out(clk_out5));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic model(input int k, input int div);
        return (k % div) >= (div / 2);
    endfunction

    // Pulse-width measurement: every edge closes the opposite phase.
    task automatic on_edge(input int idx, input logic lvl, input int hi_ns,
                           input int lo_ns, input string tag);
        real now;
        now = $realtime;
        if (!w_en[idx]) begin
            seen_rise[idx] = 1'b0;
            seen_fall[idx] = 1'b0;
        end else if (lvl === 1'b1) begin
            if (seen_fall[idx]) chk({tag, "_low_ns"}, $rtoi(now - t_fall[idx] + 0.5), lo_ns);
            t_rise[idx]    = now;
            seen_rise[idx] = 1'b1;
        end else begin
            if (seen_rise[idx]) chk({tag, "_high_ns"}, $rtoi(now - t_rise[idx] + 0.5), hi_ns);
            t_fall[idx]    = now;
            seen_fall[idx] = 1'b1;
        end
    endtask

    always @(clk_out12) on_edge(0, clk_out12, 120, 120, "d12");
    always @(clk_out2)  on_edge(1, clk_out2,  20,  20,  "d2");
    always @(clk_out5)  on_edge(2, clk_out5,  HI5_NS, LO5_NS, "d5");

    // The first rise after any reset release comes 6 edges (120 ns) after the
    // last reset edge.
    always @(posedge clk_out12) begin
        if (rise_pending) begin
            chk("d12_first_rise_ns", $rtoi($realtime - t_rel12 + 0.5), 120);
            rise_pending = 1'b0;
        end
    end

    task automatic step(input int cyc);
        exp_t e;
        exp_t got;
        k5_prev = k5;
        k12 = rst12 ? k12 + 1 : 0;
        k2  = rst2  ? k2  + 1 : 0;
        k5  = rst5  ? k5  + 1 : 0;
        e.cyc   = cyc;
        e.d12   = model(k12, 12);
        e.d2    = model(k2, 2);
        e.d5_lo = model(k5, 5);
        e.d5_hi = model(k5, 5) & (DUTY50 ? model(k5_prev, 5) : 1'b1);
        sb.push_back(e);

        @(posedge clk);
        if (!rst12) begin
            t_rel12      = $realtime;
            rise_pending = 1'b1;
        end
        #1;
        got = sb.pop_front();
        $display("t=%0t cyc=%0d rst12=%b out12=%b/%b out2=%b/%b out5=%b/%b",
                 $time, got.cyc, rst12, clk_out12, got.d12, clk_out2, got.d2,
                 clk_out5, got.d5_hi);
        chk("d12_out", clk_out12, got.d12);
        chk("d2_out",  clk_out2,  got.d2);
        chk("d5_out_hi_half", clk_out5, got.d5_hi);

        @(negedge clk);
        #1;
        chk("d5_out_lo_half", clk_out5, got.d5_lo);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        k12          = 0;
        k2           = 0;
        k5           = 0;
        k5_prev      = 0;
        rise_pending = 1'b0;
        mid_done     = 1'b0;
        t_rel12      = 0.0;
        for (int i = 0; i < 3; i++) begin
            w_en[i]      = 1'b0;
            seen_rise[i] = 1'b0;
            seen_fall[i] = 1'b0;
            t_rise[i]    = 0.0;
            t_fall[i]    = 0.0;
        end
        rst12 = 1'b0;
        rst2  = 1'b0;
        rst5  = 1'b0;

        for (int c = 0; c < N_CYC; c++) begin
            rst2  = (c >= 3);
            rst5  = (c >= 3);
            rst12 = (c >= 3);
            if (c == 10) begin
                for (int i = 0; i < 3; i++) w_en[i] = 1'b1;
            end
            if (c >= 120) w_en[0] = 1'b0;
            // One-cycle reset of DIV=12 while its output is high (cnt = 8).
            if (c >= 120 && !mid_done && (k12 % 12) == 8) begin
                rst12    = 1'b0;
                mid_done = 1'b1;
            end
            step(c);
        end

        chk("d12_mid_reset_done", {31'd0, mid_done}, 32'd1);
        chk("d12_rise_after_release", {31'd0, rise_pending}, 32'd0);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
